// File: rtl/kbd_cmd_decoder.sv
// Keyboard command decoder: synchronises and stability-filters an ASCII code, decodes E/D/B/F/R.
// Optional auto-repeat of a held command is enabled by defining KBD_AUTOREPEAT_EN.
module kbd_cmd_decoder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned REPEAT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] kbd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_id,
    output logic       playing,
    output logic       forward,
    output logic       restart,
    output logic       overrun
);
    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

    localparam logic [2:0] IdNone = 3'd0;
    localparam logic [2:0] IdE    = 3'd1;
    localparam logic [2:0] IdD    = 3'd2;
    localparam logic [2:0] IdB    = 3'd3;
    localparam logic [2:0] IdF    = 3'd4;
    localparam logic [2:0] IdR    = 3'd5;

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("kbd_cmd_decoder: illegal parameter value");
    end

    // Forcing bit 5 folds upper-case letters onto lower case.
    function automatic logic [2:0] decode_id(input logic [7:0] code);
        logic [2:0] id;
        case (code | 8'h20)
            8'h65:   id = IdE;
            8'h64:   id = IdD;
            8'h62:   id = IdB;
            8'h66:   id = IdF;
            8'h72:   id = IdR;
            default: id = IdNone;
        endcase
        return id;
    endfunction

    logic [7:0]      sync_chain_q [SYNC_STAGES];
    logic [7:0]      sync_chain_d [SYNC_STAGES];
    logic [7:0]      sync_q;
    logic [7:0]      sync_prev_q;
    logic [7:0]      last_acc_q, last_acc_d;
    logic [CntW-1:0] stable_cnt_q, stable_cnt_d;
    logic            sync_change;
    logic            accept;
    logic            rpt_fire;
    logic            cmd_evt;
    logic [2:0]      match_id;

    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_id_q, cmd_id_d;
    logic       playing_q, playing_d;
    logic       forward_q, forward_d;
    logic       restart_q, restart_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        sync_chain_d[0] = kbd_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_chain_d[i] = sync_chain_q[i-1];
        end
    end

    assign sync_q      = sync_chain_q[SYNC_STAGES-1];
    assign sync_change = (sync_q != sync_prev_q);
    assign match_id    = decode_id(sync_q);

    always_comb begin
        if (sync_change) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q == CntMax) begin
            stable_cnt_d = stable_cnt_q;
        end else begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
    end

    // A change always clears the counter, so reaching CntMax implies sync_q is steady.
    assign accept     = (stable_cnt_d == CntMax) && (sync_q != last_acc_q);
    assign last_acc_d = accept ? sync_q : last_acc_q;

`ifdef KBD_AUTOREPEAT_EN
    localparam int unsigned RptW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_CYCLES - 1);

    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_arm_q, rpt_arm_d;

    // Armed only while the last accepted matched code is still being held.
    always_comb begin
        rpt_fire  = 1'b0;
        rpt_cnt_d = rpt_cnt_q;
        rpt_arm_d = rpt_arm_q;
        if (accept) begin
            rpt_cnt_d = '0;
            rpt_arm_d = (match_id != IdNone);
        end else if (sync_change) begin
            rpt_cnt_d = '0;
            rpt_arm_d = 1'b0;
        end else if (rpt_arm_q) begin
            if (rpt_cnt_q == RptLast) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_arm_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_arm_q <= rpt_arm_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign cmd_evt = (accept || rpt_fire) && (match_id != IdNone);

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        playing_d   = playing_q;
        forward_d   = forward_q;
        restart_d   = 1'b0;
        overrun_d   = 1'b0;
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
            cmd_id_d    = IdNone;
        end
        // A new command wins over retirement; it only overruns if the old one was not taken.
        if (cmd_evt) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = match_id;
            overrun_d   = cmd_valid_q && !cmd_ready;
            case (match_id)
                IdE:     playing_d = 1'b1;
                IdD:     playing_d = 1'b0;
                IdB:     forward_d = 1'b0;
                IdF:     forward_d = 1'b1;
                IdR:     restart_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain_q[i] <= 8'h00;
            end
            sync_prev_q  <= 8'h00;
            last_acc_q   <= 8'h00;
            stable_cnt_q <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= IdNone;
            playing_q    <= 1'b0;
            forward_q    <= 1'b1;
            restart_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_chain_q <= sync_chain_d;
            sync_prev_q  <= sync_q;
            last_acc_q   <= last_acc_d;
            stable_cnt_q <= stable_cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_id_q     <= cmd_id_d;
            playing_q    <= playing_d;
            forward_q    <= forward_d;
            restart_q    <= restart_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign playing   = playing_q;
    assign forward   = forward_q;
    assign restart   = restart_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Bench for kbd_cmd_decoder: directed and random key streams against a windowed reference model,
// with a per-cycle scoreboard. Honours KBD_AUTOREPEAT_EN when the design is built with it.
module tb_kbd_cmd_decoder;
    localparam int SyncStages   = 2;
    localparam int StableCycles = 4;
    localparam int RepeatCycles = 10;
    localparam int HistLen      = SyncStages + StableCycles + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_id;
    logic       playing;
    logic       forward;
    logic       restart;
    logic       overrun;

    always #5 clk = ~clk;

    kbd_cmd_decoder #(
        .SYNC_STAGES  (SyncStages),
        .STABLE_CYCLES(StableCycles),
        .REPEAT_CYCLES(RepeatCycles)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .kbd_data (kbd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_id   (cmd_id),
        .playing  (playing),
        .forward  (forward),
        .restart  (restart),
        .overrun  (overrun)
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
        logic       play;
        logic       fwd;
        logic       rst;
        logic       ovr;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Command letters in id order (id = index + 1), lower case.
    function automatic logic [2:0] ref_id(input logic [7:0] c);
        logic [7:0] letters [5];
        letters = '{8'h65, 8'h64, 8'h62, 8'h66, 8'h72};
        for (int i = 0; i < 5; i++) begin
            if ((c | 8'h20) == letters[i]) return 3'(i + 1);
        end
        return 3'd0;
    endfunction

    // Reference model: hist holds the raw input seen at each rising edge (newest last).
    logic [7:0] hist[$];
    logic [7:0] m_last, m_v, m_arm_code;
    logic       m_valid, m_play, m_fwd, m_arm, m_acc, m_fire, m_ev, m_pend;
    logic [2:0] m_id, m_new_id;
    int         m_edge, m_arm_edge;
    out_t       m_out;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
                for (int i = 0; i < HistLen; i++) hist.push_back(8'h00);
                m_last = 8'h00; m_valid = 1'b0; m_id = 3'd0; m_play = 1'b0; m_fwd = 1'b1;
                m_arm = 1'b0; m_arm_code = 8'h00; m_edge = 0; m_arm_edge = 0;
                m_out = '{valid: 1'b0, id: 3'd0, play: 1'b0, fwd: 1'b1, rst: 1'b0, ovr: 1'b0};
                exp_q.delete();
                exp_q.push_back(m_out);
            end else begin
                hist.push_back(kbd_data);
                hist.delete(0);
                m_edge++;
                // A code is taken once it was seen on StableCycles+1 consecutive edges,
                // counted SyncStages edges back, and differs from the last taken code.
                m_v   = hist[HistLen - 1 - SyncStages];
                m_acc = (m_v != m_last);
                for (int j = SyncStages; j <= SyncStages + StableCycles; j++) begin
                    if (hist[HistLen - 1 - j] != m_v) m_acc = 1'b0;
                end
                m_fire = 1'b0;
`ifdef KBD_AUTOREPEAT_EN
                if (m_arm && m_v != m_arm_code) m_arm = 1'b0;
                if (m_arm && !m_acc && ((m_edge - m_arm_edge) % RepeatCycles == 0)) m_fire = 1'b1;
                if (m_acc) begin
                    m_arm      = (ref_id(m_v) != 3'd0);
                    m_arm_code = m_v;
                    m_arm_edge = m_edge;
                end
`endif
                if (m_acc) m_last = m_v;
                m_new_id = ref_id(m_v);
                m_ev     = (m_acc || m_fire) && (m_new_id != 3'd0);
                m_pend   = m_valid;
                m_out.rst = 1'b0;
                m_out.ovr = 1'b0;
                if (m_pend && cmd_ready) begin
                    m_valid = 1'b0;
                    m_id    = 3'd0;
                end
                if (m_ev) begin
                    m_out.ovr = m_pend && !cmd_ready;
                    m_valid   = 1'b1;
                    m_id      = m_new_id;
                    if (m_new_id == 3'd1) m_play = 1'b1;
                    if (m_new_id == 3'd2) m_play = 1'b0;
                    if (m_new_id == 3'd3) m_fwd = 1'b0;
                    if (m_new_id == 3'd4) m_fwd = 1'b1;
                    if (m_new_id == 3'd5) m_out.rst = 1'b1;
                end
                m_out.valid = m_valid;
                m_out.id    = m_id;
                m_out.play  = m_play;
                m_out.fwd   = m_fwd;
                exp_q.push_back(m_out);
            end
        end
    end

    // Monitor: every falling edge, the DUT outputs are compared to the oldest expectation.
    int   mon_cycle = 0;
    out_t act, want;
    initial begin
        forever begin
            @(negedge clk);
            mon_cycle++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                act  = '{valid: cmd_valid, id: cmd_id, play: playing, fwd: forward,
                         rst: restart, ovr: overrun};
                checks++;
                if (act !== want) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d actual v=%b id=%0d play=%b fwd=%b rst=%b ovr=%b required v=%b id=%0d play=%b fwd=%b rst=%b ovr=%b",
                             mon_cycle, act.valid, act.id, act.play, act.fwd, act.rst, act.ovr,
                             want.valid, want.id, want.play, want.fwd, want.rst, want.ovr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] c, input int n);
        kbd_data = c;
        tick(n);
    endtask

    task automatic take_one();
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
    endtask

    task automatic expect_eq(input string what, input logic [7:0] actual,
                             input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", what, actual, required, $time);
        end
    endtask

    task automatic wait_valid(input int max_cycles);
        int waited;
        waited = 0;
        while (cmd_valid !== 1'b1 && waited < max_cycles) begin
            tick(1);
            waited++;
        end
        checks++;
        if (cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout waiting for cmd_valid after %0d cycles at %0t",
                     max_cycles, $time);
        end
    endtask

    logic [7:0] pool [11];
    logic [7:0] code;
    int         hold;

    initial begin
        pool = '{8'h45, 8'h65, 8'h44, 8'h64, 8'h42, 8'h62, 8'h46, 8'h66, 8'h52, 8'h72, 8'h00};
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Reset state.
        expect_eq("reset cmd_valid", 8'(cmd_valid), 8'h00);
        expect_eq("reset playing", 8'(playing), 8'h00);
        expect_eq("reset forward", 8'(forward), 8'h01);

        // Basic accept of 'E', then retire it.
        key(8'h45, 10);
        wait_valid(20);
        expect_eq("accept cmd_id", 8'(cmd_id), 8'h01);
        expect_eq("accept playing", 8'(playing), 8'h01);
        take_one();

        // Lower-case 'b', then a short 'r' glitch that must be rejected.
        key(8'h62, 10);
        take_one();
        key(8'h72, 3);
        key(8'h62, 10);

        // 'F', release, 'R' with nothing retired: overrun.
        key(8'h46, 8);
        key(8'h00, 8);
        key(8'h52, 8);
        take_one();

        // 'E' pending, 'D' accepted on the same edge cmd_ready is high.
        key(8'h00, 8);
        key(8'h45, 10);
        kbd_data = 8'h44;
        tick(StableCycles + SyncStages);
        take_one();
        tick(4);

        // Reset mid-operation while 'E' pending and 'd' stabilising; 'E' held through release.
        key(8'h00, 8);
        key(8'h45, 10);
        kbd_data = 8'h64;
        tick(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        kbd_data = 8'h45;
        tick(3);
        #2 rst_n = 1'b1;
        tick(12);
        take_one();

        // Held 'R' with the consumer always ready.
        cmd_ready = 1'b1;
        key(8'h00, 8);
        key(8'h52, 45);
        key(8'h00, 8);
        cmd_ready = 1'b0;

        // Random key streams with random consumer back-pressure.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 11) == 0) code = 8'($urandom_range(0, 255));
            else code = pool[$urandom_range(0, 10)];
            hold = $urandom_range(1, 10);
            kbd_data = code;
            for (int c = 0; c < hold; c++) begin
                cmd_ready = ($urandom_range(0, 2) == 0);
                tick(1);
            end
            if (it == 120) begin
                #3 rst_n = 1'b0;
                tick(2);
                #3 rst_n = 1'b1;
            end
        end
        cmd_ready = 1'b0;
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
